// File: rtl/train_step_pkg.sv
// Shared definitions for the train-step MAC pipeline: group FSM encoding and
// saturation limit helpers used by the accumulator.
package train_step_pkg;

    localparam int MAX_ACC_W = 64;

    typedef enum logic {
        GRP_EMPTY = 1'b0,
        GRP_ACCUM = 1'b1
    } grp_state_e;

    // Largest positive two's-complement value of a w-bit word, returned in the
    // low w bits; callers narrow it with a size cast. Valid for w <= MAX_ACC_W.
    function automatic logic [MAX_ACC_W-1:0] satMax(input int w);
        satMax = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - w + 1);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] satMin(input int w);
        satMin = satMax(w) + 1'b1;
    endfunction

endpackage

// File: rtl/train_step_mul_pipe.sv
// Signed multiplier followed by NUM_STAGE enable-gated registers that carry the
// sign-extended product together with its valid and last tags.
module train_step_mul_pipe
    import train_step_pkg::*;
#(
    parameter int A_W       = 14,
    parameter int B_W       = 12,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic signed [A_W-1:0]       a_i,
    input  logic signed [B_W-1:0]       b_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic signed [ACC_WIDTH-1:0] prod_o,
    output logic                        valid_o,
    output logic                        last_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]       rawProd;
    logic signed [ACC_WIDTH-1:0] extProd;
    logic signed [ACC_WIDTH-1:0] prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]        valid_q;
    logic [NUM_STAGE-1:0]        last_q;

    assign rawProd = P_W'(a_i) * P_W'(b_i);
    assign extProd = ACC_WIDTH'(rawProd);

    // The whole chain freezes together so a stalled beat is neither lost nor repeated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en_i) begin
            prod_q[0]  <= extProd;
            valid_q[0] <= valid_i;
            last_q[0]  <= last_i;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i]  <= prod_q[i-1];
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign prod_o  = prod_q[NUM_STAGE-1];
    assign valid_o = valid_q[NUM_STAGE-1];
    assign last_o  = last_q[NUM_STAGE-1];

endmodule

// File: rtl/train_step_mac_pipe.sv
// Pipelined signed multiply-accumulate over groups of beats delimited by in_last,
// with per-group overflow detection, optional saturation and a stallable result register.
module train_step_mac_pipe
    import train_step_pkg::*;
#(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 2,
    parameter int SATURATE   = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [ACC_WIDTH-1:0]  dout,
    output logic                         dout_ovf,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(satMax(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(satMin(ACC_WIDTH));
    localparam int                   MSB     = ACC_WIDTH - 1;

    grp_state_e                  state_q;
    logic signed [ACC_WIDTH-1:0] accSum_q;
    logic                        sticky_q;
    logic signed [ACC_WIDTH-1:0] dout_q;
    logic                        doutOvf_q;
    logic                        outValid_q;

    logic                        en;
    logic signed [ACC_WIDTH-1:0] pProd;
    logic                        pValid;
    logic                        pLast;
    logic signed [ACC_WIDTH-1:0] accBase;
    logic signed [ACC_WIDTH-1:0] rawSum;
    logic                        addOvf;
    logic signed [ACC_WIDTH-1:0] nextSum_d;

    // Everything advances unless a held result is waiting on the consumer.
    assign en       = !(outValid_q && !out_ready);
    assign in_ready = en;

    train_step_mul_pipe #(
        .A_W       (DIN0_WIDTH),
        .B_W       (DIN1_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul_pipe (
        .clk_i   (ap_clk),
        .rst_ni  (ap_rst_n),
        .en_i    (en),
        .a_i     (din0),
        .b_i     (din1),
        .valid_i (in_valid),
        .last_i  (in_last),
        .prod_o  (pProd),
        .valid_o (pValid),
        .last_o  (pLast)
    );

    // Overflow only when both addends share a sign that the sum does not keep.
    always_comb begin
        accBase   = (state_q == GRP_ACCUM) ? accSum_q : '0;
        rawSum    = accBase + pProd;
        addOvf    = (accBase[MSB] == pProd[MSB]) && (rawSum[MSB] != accBase[MSB]);
        nextSum_d = rawSum;
        if ((SATURATE != 0) && addOvf) begin
            nextSum_d = accBase[MSB] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= GRP_EMPTY;
            accSum_q   <= '0;
            sticky_q   <= 1'b0;
            dout_q     <= '0;
            doutOvf_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end
            if (en && pValid) begin
                if (pLast) begin
                    dout_q     <= nextSum_d;
                    doutOvf_q  <= sticky_q | addOvf;
                    outValid_q <= 1'b1;
                    accSum_q   <= '0;
                    sticky_q   <= 1'b0;
                    state_q    <= GRP_EMPTY;
                end else begin
                    accSum_q   <= nextSum_d;
                    sticky_q   <= sticky_q | addOvf;
                    state_q    <= GRP_ACCUM;
                end
            end
        end
    end

    assign dout      = dout_q;
    assign dout_ovf  = doutOvf_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_train_step_mac_pipe.sv
// Scoreboard bench for train_step_mac_pipe: a default instance checked against a
// group-sum model, plus 26-bit saturating and wrapping instances on shared stimulus.
module tb_train_step_mac_pipe;

    localparam longint MODEL_MAX = 64'sd2147483647;
    localparam longint MODEL_MIN = -MODEL_MAX - 1;

    logic               clk = 1'b0;
    logic               rstN;
    logic signed [13:0] din0;
    logic signed [11:0] din1;
    logic               inLast;
    logic               inValid;
    logic               outReady;
    logic               inReady0, inReady1, inReady2;
    logic signed [31:0] dout0;
    logic signed [25:0] dout1, dout2;
    logic               ovf0, ovf1, ovf2;
    logic               outValid0, outValid1, outValid2;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [32:0] expQ[$];
    logic [32:0] monExp;
    longint      grpAcc = 0;
    bit          grpOvf = 0;

    always #5 clk = ~clk;

    train_step_mac_pipe dut0 (
        .ap_clk(clk), .ap_rst_n(rstN), .din0(din0), .din1(din1),
        .in_last(inLast), .in_valid(inValid), .in_ready(inReady0),
        .dout(dout0), .dout_ovf(ovf0), .out_valid(outValid0), .out_ready(outReady)
    );

    train_step_mac_pipe #(.ACC_WIDTH(26), .SATURATE(1)) dutSat (
        .ap_clk(clk), .ap_rst_n(rstN), .din0(din0), .din1(din1),
        .in_last(inLast), .in_valid(inValid), .in_ready(inReady1),
        .dout(dout1), .dout_ovf(ovf1), .out_valid(outValid1), .out_ready(outReady)
    );

    train_step_mac_pipe #(.ACC_WIDTH(26), .SATURATE(0)) dutWrap (
        .ap_clk(clk), .ap_rst_n(rstN), .din0(din0), .din1(din1),
        .in_last(inLast), .in_valid(inValid), .in_ready(inReady2),
        .dout(dout2), .dout_ovf(ovf2), .out_valid(outValid2), .out_ready(outReady)
    );

    // Results are retired at the negedge preceding the edge that completes the handshake.
    always @(negedge clk) begin
        if (rstN && outValid0 && outReady) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_result dout=%0d ovf=%0b required=none", dout0, ovf0);
            end else begin
                monExp = expQ.pop_front();
                if ({ovf0, dout0} !== monExp) begin
                    miscompares++;
                    $display("[TB] FAIL result dout=%0d ovf=%0b required dout=%0d ovf=%0b",
                             dout0, ovf0, $signed(monExp[31:0]), monExp[32]);
                end
            end
        end
    end

    // Group model for the default instance: 32-bit saturating sum with sticky overflow.
    task automatic modelBeat(input int a, input int b, input bit last);
        longint s;
        bit     o;
        s = grpAcc + longint'(a) * longint'(b);
        o = 1'b0;
        if (s > MODEL_MAX) begin
            o = 1'b1;
            s = MODEL_MAX;
        end else if (s < MODEL_MIN) begin
            o = 1'b1;
            s = MODEL_MIN;
        end
        grpOvf = grpOvf | o;
        if (last) begin
            expQ.push_back({grpOvf, 32'(s)});
            grpAcc = 0;
            grpOvf = 1'b0;
        end else begin
            grpAcc = s;
        end
    endtask

    // Presents one beat and holds it until accepted; waits counts edges spent.
    task automatic applyStimulus(input int a, input int b, input bit last, output int waits);
        bit taken;
        din0    = 14'(a);
        din1    = 12'(b);
        inLast  = last;
        inValid = 1'b1;
        waits   = 0;
        taken   = 1'b0;
        while (!taken && waits < 50) begin
            @(negedge clk);
            taken = inReady0;
            @(posedge clk);
            #1;
            waits++;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        if (taken) begin
            modelBeat(a, b, last);
        end else begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout in_ready=%0b required=1", inReady0);
        end
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 60 && expQ.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        outReady = 1'b1;
        inValid  = 1'b0;
        inLast   = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 4;
        if (outValid0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid got=%0b required=0", outValid0);
        end
        if (dout0 !== 32'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dout got=%0d required=0", dout0);
        end
        if (ovf0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ovf got=%0b required=0", ovf0);
        end
        if (inReady0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready got=%0b required=1", inReady0);
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_basic_group();
        int w;
        int lat;
        bit found;
        applyStimulus(3, 4, 1'b0, w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("[TB] FAIL first_accept edges=%0d required=1", w);
        end
        applyStimulus(-5, 2, 1'b0, w);
        applyStimulus(7, -1, 1'b1, w);
        lat   = 1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (outValid0) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        vectors += 2;
        if (!found || lat != 3) begin
            miscompares++;
            $display("[TB] FAIL latency cycles=%0d required=3", lat);
        end
        if (dout0 !== -32'sd5) begin
            miscompares++;
            $display("[TB] FAIL basic_sum got=%0d required=-5", dout0);
        end
        waitDrain();
    endtask

    task automatic test_saturation();
        int w;
        bit found;
        applyStimulus(-8192, -2048, 1'b0, w);
        applyStimulus(-8192, -2048, 1'b1, w);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = outValid1;
        end
        vectors += 5;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL sat_timeout out_valid=%0b required=1", outValid1);
        end
        if ({ovf1, dout1} !== {1'b1, 26'h1FFFFFF}) begin
            miscompares++;
            $display("[TB] FAIL saturate dout=%0d ovf=%0b required dout=33554431 ovf=1", dout1, ovf1);
        end
        if ({ovf2, dout2} !== {1'b1, 26'h2000000}) begin
            miscompares++;
            $display("[TB] FAIL wrap dout=%0d ovf=%0b required dout=-33554432 ovf=1", dout2, ovf2);
        end
        if (outValid2 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_valid got=%0b required=1", outValid2);
        end
        if (dout0 !== 32'sd33554432) begin
            miscompares++;
            $display("[TB] FAIL wide_sum got=%0d required=33554432", dout0);
        end
        waitDrain();
    endtask

    task automatic test_backpressure();
        fork
            begin
                int w;
                for (int i = 1; i <= 8; i++) begin
                    applyStimulus(i, 1, 1'b1, w);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                outReady = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    vectors++;
                    if (inReady0 !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL stall_in_ready cycle=%0d got=%0b required=0", k, inReady0);
                    end
                    @(posedge clk);
                    #1;
                end
                outReady = 1'b1;
            end
        join
        waitDrain();
    endtask

    task automatic test_back_to_back();
        int count;
        bit found;
        repeat (2) @(posedge clk);
        #1;
        fork
            begin
                int w;
                for (int i = 1; i <= 6; i++) begin
                    applyStimulus(i, -3, 1'b1, w);
                end
            end
            begin
                found = 1'b0;
                for (int k = 0; k < 20 && !found; k++) begin
                    @(negedge clk);
                    found = outValid0;
                end
                count = 0;
                if (found) begin
                    do begin
                        count++;
                        @(negedge clk);
                    end while (outValid0 && count < 20);
                end
                vectors++;
                if (count != 6) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_valid_run cycles=%0d required=6", count);
                end
            end
        join
        waitDrain();
    endtask

    task automatic test_reset_mid_group();
        int w;
        applyStimulus(5, 5, 1'b0, w);
        applyStimulus(4, 4, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        rstN   = 1'b0;
        grpAcc = 0;
        grpOvf = 1'b0;
        expQ.delete();
        #2;
        vectors += 2;
        if (inReady0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_in_ready got=%0b required=1", inReady0);
        end
        if (outValid0 !== 1'b0 || dout0 !== 32'sd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs valid=%0b dout=%0d required valid=0 dout=0", outValid0, dout0);
        end
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(2, 3, 1'b1, w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_accept edges=%0d required=1", w);
        end
        waitDrain();
    endtask

    initial begin
        test_reset();
        test_basic_group();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_group();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/train_step_mac_pipe.md
TRAIN_STEP_MAC_PIPE -- requirements
Module: train_step_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 14, signed width of operand din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 12, signed width of operand din1.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, signed accumulator/result width; legal range is at least DIN0_WIDTH+DIN1_WIDTH.
REQ-004 SHALL have parameter NUM_STAGE, default 2, multiplier pipeline depth; legal range is 1..4.
REQ-005 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 SHALL have port ap_clk  in  1  single clock, rising edge.
REQ-007 SHALL have port ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port din0  in  DIN0_WIDTH  signed operand A.
REQ-009 SHALL have port din1  in  DIN1_WIDTH  signed operand B.
REQ-010 SHALL have port in_last  in  1  marks the final beat of an accumulation group.
REQ-011 SHALL have port in_valid  in  1  input beat valid.
REQ-012 SHALL have port in_ready  out  1  block accepts a beat.
REQ-013 SHALL have port dout  out  ACC_WIDTH  signed group sum.
REQ-014 SHALL have port dout_ovf  out  1  an overflow occurred in the group.
REQ-015 SHALL have port out_valid  out  1  dout/dout_ovf valid.
REQ-016 SHALL have port out_ready  in  1  consumer accepts the result.

Function
REQ-017 SHALL define a global advance enable en = !(out_valid && !out_ready); in_ready SHALL equal en.
REQ-018 SHALL accept a beat when in_valid && in_ready.
REQ-019 SHALL compute product = $signed(din0)*$signed(din1) at full width DIN0_WIDTH+DIN1_WIDTH, then sign-extend it to ACC_WIDTH.
REQ-020 SHALL pipeline product, valid and last through NUM_STAGE registers, all of which advance only when en=1.
REQ-021 SHALL hold every pipeline register unchanged while en=0; no beat is lost or duplicated.
REQ-022 SHALL implement group FSM EMPTY (acc=0, ovf=0) and ACCUM: a valid non-last product at pipeline exit with en=1 moves the FSM to ACCUM and sets acc+=product; a valid last product produces a result and returns the FSM to EMPTY.
REQ-023 SHALL detect signed overflow of acc+product, ignoring the sign-carry; SATURATE=1 clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1); SATURATE=0 wraps.
REQ-024 SHALL make the group overflow flag sticky until the group's result is issued.
REQ-025 SHALL, on the last product with en=1, load dout = final sum (including that product) and dout_ovf = sticky|current overflow, and set out_valid=1; acc and the flag clear in the same cycle.
REQ-026 SHALL, on out_valid && out_ready with no new result that cycle, clear out_valid; if a new result arrives in the same cycle, load it and keep out_valid=1.
REQ-027 SHALL have a latency from acceptance of the last beat to out_valid=1 of exactly NUM_STAGE+1 cycles when out_ready=1 throughout.
REQ-028 SHALL sustain throughput of one beat per cycle when out_ready=1.
REQ-029 SHALL treat a single-beat group (in_last on first beat) as sum = product.
REQ-030 SHALL keep dout and dout_ovf stable while out_valid && !out_ready.

Reset
REQ-031 SHALL, with ap_rst_n low, asynchronously force all pipeline valids to 0, acc=0, the sticky flag to 0, FSM=EMPTY, out_valid=0, dout=0 and dout_ovf=0.
REQ-032 SHALL discard any partial group or in-flight beat on reset mid-operation; in_ready SHALL read 1 during and after reset.
REQ-033 SHALL sample reset deassertion synchronously (rising edge of ap_clk, ap_rst_n high); the first beat SHALL be accepted on the first edge after release.

Structure
REQ-034 SHALL take FSM state encoding and saturation-limit constant functions from shared package train_step_pkg.
REQ-035 SHALL instantiate one sub-module, train_step_mul_pipe (parametrised signed multiplier with NUM_STAGE enable-gated registers); accumulation, FSM and output register remain in the top.

Verification
REQ-036 SHALL cover the basic group (defaults): beats (3,4),(−5,2),(7,−1,last) with out_ready=1 -> dout=−5, dout_ovf=0, out_valid exactly 3 cycles after the last beat is accepted.
REQ-037 SHALL cover saturation: ACC_WIDTH=26, SATURATE=1, two beats (−8192,−2048) with last on the second -> dout=33554431, dout_ovf=1.
REQ-038 SHALL cover wrap: the same stimulus as REQ-037 with SATURATE=0 -> dout=−33554432, dout_ovf=1.
REQ-039 SHALL cover backpressure: streaming single-beat groups (i,1), i=1..8, with out_ready low for 5 cycles mid-stream -> in_ready low while stalled and outputs 1..8 in order, none lost or duplicated.
REQ-040 SHALL cover back-to-back results: out_ready=1 and consecutive single-beat groups -> out_valid held high, a new dout every cycle.
REQ-041 SHALL cover reset mid-group: reset asserted after 2 of 3 beats, then group (2,3,last) -> dout=6, with no carry-over from the discarded group.
